// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch front end. Issues pipelined requests over
// a req/gnt/rvalid handshake and buffers {pc, instr} pairs in a prefetch FIFO.
// A redirect flushes the FIFO and turns in-flight requests into discards.
module if_prefetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_MAX   = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] C_QLAST = QW'(MAX_OUTSTANDING - 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_live_cnt;
  logic [CW-1:0]   r_discard_cnt;
  logic [CW-1:0]   r_fifo_cnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_q_pc       [MAX_OUTSTANDING];
  logic [QW-1:0]   r_q_wr;
  logic [QW-1:0]   r_q_rd;

  logic [CW-1:0]    w_total;
  logic             w_issue;
  logic             w_live_rsp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_redirect_target;
  logic [DEPTH-1:0] w_fifo_we;
  logic [QW-1:0]    w_q_wr_next;
  logic [QW-1:0]    w_q_rd_next;

  // Credit rule: a live request always has a FIFO slot reserved, so an
  // rvalid can never find the FIFO full. Held low while in reset.
  assign w_total    = r_live_cnt + r_discard_cnt;
  assign imem_req   = reset_n && !redirect_valid && (w_total < C_MAX) &&
                      ((r_fifo_cnt + r_live_cnt) < C_DEPTH);
  assign imem_addr  = r_fetch_pc;
  assign w_issue    = imem_req && imem_gnt;
  // Killed requests come back first (in-order memory), so drain them before live data.
  assign w_drop     = imem_rvalid && (r_discard_cnt != '0);
  assign w_live_rsp = imem_rvalid && (r_discard_cnt == '0);
  assign w_push     = w_live_rsp && !redirect_valid;
  assign w_pop      = out_valid && out_ready && !redirect_valid;
  assign w_redirect_target = redirect_pc & ~XLEN'(3);

  assign out_valid = (r_fifo_cnt != '0);
  assign out_pc    = r_fifo_pc[r_rd_ptr];
  assign out_instr = r_fifo_instr[r_rd_ptr];

  // PC queue pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
  assign w_q_wr_next = (r_q_wr == C_QLAST) ? '0 : r_q_wr + QW'(1);
  assign w_q_rd_next = (r_q_rd == C_QLAST) ? '0 : r_q_rd + QW'(1);

  // One-hot write enable per FIFO slot.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_fifo_we[gi] = w_push && (r_wr_ptr == PW'(gi));
    end
  endgenerate

  // Fetch PC plus live/discard accounting; a redirect moves live requests to discards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_live_cnt    <= '0;
      r_discard_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_target;
      r_live_cnt    <= '0;
      r_discard_cnt <= r_discard_cnt + r_live_cnt - CW'(imem_rvalid);
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_live_cnt    <= r_live_cnt + CW'(w_issue) - CW'(w_live_rsp);
      r_discard_cnt <= r_discard_cnt - CW'(w_drop);
    end
  end

  // In-flight PC queue pointers; cleared on redirect since every entry becomes a discard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_wr <= '0;
      r_q_rd <= '0;
    end else if (redirect_valid) begin
      r_q_wr <= '0;
      r_q_rd <= '0;
    end else begin
      if (w_issue)    r_q_wr <= w_q_wr_next;
      if (w_live_rsp) r_q_rd <= w_q_rd_next;
    end
  end

  // In-flight PC storage, written at issue time.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_q_pc[r_q_wr] <= r_fetch_pc;
    end
  end

  // Prefetch FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PW'(w_push);
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Prefetch FIFO storage: returned word paired with the PC popped from the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= RESET_PC;
        r_fifo_instr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_fifo_we[i]) begin
          r_fifo_pc[i]    <= r_q_pc[r_q_rd];
          r_fifo_instr[i] <= imem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed scenarios plus randomized traffic against a
// queue-level reference model of the fetch front end and a latency memory model.
module tb_if_prefetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // memory model: in-order responses with per-request latency
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int lat_min = 1;
  int lat_max = 1;
  int last_due = -1;

  // reference model: FIFO contents, live PCs in flight, killed count
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_fifo[$];
  logic [31:0] m_inflight[$];
  int          m_discard = 0;
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_expect_pc = RESET_PC;

  // per-cycle logs for hand-computed checks
  logic        req_log   [64];
  logic [31:0] addr_log  [64];
  logic        valid_log [64];
  typedef struct { int c; logic [31:0] pc; } pop_t;
  pop_t        pop_log[$];
  logic [31:0] issue_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_inflight.delete();
    m_discard   = 0;
    m_fetch_pc  = RESET_PC;
    m_expect_pc = RESET_PC;
    mem_q.delete();
    last_due = -1;
    pop_log.delete();
    issue_log.delete();
    for (int i = 0; i < 64; i++) begin
      req_log[i]   = 1'b0;
      addr_log[i]  = '0;
      valid_log[i] = 1'b0;
    end
  endtask

  // Asynchronous reset, checked immediately, released just after a rising edge.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_imem_req",  32'(imem_req),  32'(1'b0));
    chk("rst_imem_addr", imem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks at posedge+2,
  // advances memory and reference model, returns at the next posedge+1.
  task automatic cycle(input int gnt_pct, input int ready_pct, input bit redir,
                       input logic [31:0] rpc);
    logic        gnt_v, rdy_v, rv, exp_req;
    logic [31:0] rd;
    int          live, due;
    ent_t        e;
    gnt_v = ($urandom_range(99) < gnt_pct);
    rdy_v = ($urandom_range(99) < ready_pct);
    rv = 1'b0;
    rd = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy_v;
    imem_gnt       = gnt_v;
    imem_rvalid    = rv;
    imem_rdata     = rd;
    #1;
    live    = m_inflight.size();
    exp_req = !redir && (live + m_discard < MAXO) && (m_fifo.size() + live < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("out_pc",    out_pc,    m_fifo[0].pc);
      chk("out_instr", out_instr, m_fifo[0].instr);
    end
    if (cyc < 64) begin
      req_log[cyc]   = imem_req;
      addr_log[cyc]  = imem_addr;
      valid_log[cyc] = out_valid;
    end
    // memory accepts whatever the DUT actually issues
    if (imem_req && imem_gnt) begin
      issue_log.push_back(imem_addr);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_addr, due: due});
    end
    // decode side: every accepted instruction continues the current fetch stream
    if (out_valid && out_ready && !redir) begin
      pop_log.push_back('{c: cyc, pc: out_pc});
      $display("POP  cyc=%0d pc=%h instr=%h", cyc, out_pc, out_instr);
      chk("stream_pc",    out_pc,    m_expect_pc);
      chk("stream_instr", out_instr, mem_word(out_pc));
      m_expect_pc = m_expect_pc + 32'd4;
    end
    // reference model state update
    if (redir) begin
      m_fifo.delete();
      m_discard = m_discard + live - (rv ? 1 : 0);
      if (m_discard < 0) m_discard = 0;
      m_inflight.delete();
      m_fetch_pc  = rpc & ~32'h3;
      m_expect_pc = rpc & ~32'h3;
    end else begin
      if (m_fifo.size() != 0 && rdy_v) void'(m_fifo.pop_front());
      if (rv) begin
        if (m_discard > 0) begin
          m_discard--;
        end else if (m_inflight.size() > 0) begin
          e.pc    = m_inflight.pop_front();
          e.instr = rd;
          m_fifo.push_back(e);
        end else begin
          checks++;
          errors++;
          $display("FAIL spurious_rvalid cyc=%0d actual=response required=no_request_outstanding", cyc);
        end
      end
      if (exp_req && gnt_v) begin
        m_inflight.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int v;
    logic [31:0] rpc;
    #2;

    // A: zero-wait memory, decode always ready
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) cycle(100, 100, 1'b0, '0);
    chk("A_pop0_cyc", 32'(pop_log[0].c), 32'd2);
    chk("A_pop0_pc",  pop_log[0].pc, 32'h0);
    chk("A_pop1_cyc", 32'(pop_log[1].c), 32'd3);
    chk("A_pop1_pc",  pop_log[1].pc, 32'h4);
    chk("A_pop5_pc",  pop_log[5].pc, 32'h14);
    chk("A_pop_count", 32'(pop_log.size()), 32'd10);

    // B: decode stalled until credit runs out, then drained
    do_reset();
    repeat (8) cycle(100, 0, 1'b0, '0);
    chk("B_issue_count", 32'(issue_log.size()), 32'd4);
    chk("B_req_idle",    32'(req_log[7]),   32'(1'b0));
    chk("B_fifo_valid",  32'(valid_log[7]), 32'(1'b1));
    repeat (10) cycle(100, 100, 1'b0, '0);
    chk("B_drain0", pop_log[0].pc, 32'h0);
    chk("B_drain1", pop_log[1].pc, 32'h4);
    chk("B_drain2", pop_log[2].pc, 32'h8);
    chk("B_drain3", pop_log[3].pc, 32'hC);
    chk("B_drain0_cyc", 32'(pop_log[0].c), 32'd8);
    chk("B_req_c8",  32'(req_log[8]), 32'(1'b0));
    chk("B_req_c9",  32'(req_log[9]), 32'(1'b1));
    chk("B_addr_c9", addr_log[9], 32'h10);
    chk("B_issue4",  issue_log[4], 32'h10);

    // C: grant withheld for three cycles while requesting 0x8
    do_reset();
    for (int i = 0; i < 12; i++) cycle((i >= 2 && i <= 4) ? 0 : 100, 100, 1'b0, '0);
    chk("C_addr_c2", addr_log[2], 32'h8);
    chk("C_addr_c3", addr_log[3], 32'h8);
    chk("C_addr_c4", addr_log[4], 32'h8);
    chk("C_req_c3",  32'(req_log[3]), 32'(1'b1));
    chk("C_issue2",  issue_log[2], 32'h8);
    chk("C_issue3",  issue_log[3], 32'hC);
    chk("C_pop2",    pop_log[2].pc, 32'h8);
    chk("C_pop3",    pop_log[3].pc, 32'hC);

    // D: redirect to 0x103 with two requests in flight, 3-cycle memory
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 14; i++) cycle(100, 100, (i == 2), 32'h103);
    chk("D_req_redirect", 32'(req_log[2]), 32'(1'b0));
    v = 0;
    for (int c = 0; c < 8; c++) v += int'(valid_log[c]);
    chk("D_no_stale", 32'(v), 32'd0);
    chk("D_issue2",   issue_log[2], 32'h100);
    chk("D_pop0_pc",  pop_log[0].pc, 32'h100);
    chk("D_pop0_cyc", 32'(pop_log[0].c), 32'd8);
    chk("D_pop1_pc",  pop_log[1].pc, 32'h104);

    // E: redirect coinciding with rvalid and a decode pop
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(100, 100, (i == 4), 32'h200);
    chk("E_req_redirect", 32'(req_log[4]), 32'(1'b0));
    chk("E_valid_after",  32'(valid_log[5]), 32'(1'b0));
    chk("E_req_after",    32'(req_log[5]), 32'(1'b1));
    chk("E_addr_after",   addr_log[5], 32'h200);
    chk("E_pop2_pc",      pop_log[2].pc, 32'h200);
    chk("E_pop2_cyc",     32'(pop_log[2].c), 32'd7);

    // F: reset mid-stream with three FIFO entries
    do_reset();
    repeat (4) cycle(100, 0, 1'b0, '0);
    chk("F_pre_valid", 32'(out_valid), 32'(1'b1));
    chk("F_pre_pc",    out_pc, 32'h0);
    do_reset();
    repeat (6) cycle(100, 100, 1'b0, '0);
    chk("F_restart_req",  32'(req_log[0]), 32'(1'b1));
    chk("F_restart_addr", addr_log[0], RESET_PC);
    chk("F_restart_pop",  pop_log[0].pc, RESET_PC);

    // G: randomized traffic, redirects including near the top of the address space
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom;
      cycle(70, 70, ($urandom_range(99) < 4), rpc);
    end
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 500; i++) begin
      rpc = $urandom;
      cycle(100, 100, ($urandom_range(99) < 2), rpc);
    end
    lat_min = 2; lat_max = 5;
    for (int i = 0; i < 500; i++) begin
      rpc = $urandom;
      cycle(90, 20, ($urandom_range(99) < 3), rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch front end that replaces the single-PC fetch stage. It issues pipelined requests to a variable-latency instruction memory over a req/gnt/rvalid handshake and buffers returned {pc, instr} pairs in a prefetch FIFO. The decode stage drains them through a valid/ready interface. A redirect from the branch unit flushes the FIFO and discards responses that are still in flight. The block sits between the PC/branch logic and the IF/ID boundary.

## Interface
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  out  1  FIFO head valid toward decode
- out_ready  in  1  decode accepts head; low = stall
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  XLEN  head instruction word
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address, word aligned
- imem_gnt  in  1  request accepted this cycle (req && gnt = issue)
- imem_rvalid  in  1  response valid; responses return in request order, never back-pressured
- imem_rdata  in  XLEN  response data

## Operation
- fetch_pc register; reset value RESET_PC. Each issue increments it by 4, with modulo-2^XLEN wrap.
- In-flight PC queue (MAX_OUTSTANDING entries): push fetch_pc on issue. Pop on each live response; the response then writes {popped pc, imem_rdata} into the prefetch FIFO.
- live_cnt = live outstanding requests. discard_cnt = killed outstanding requests. total = live_cnt + discard_cnt.
- Issue condition (imem_req = 1) requires all of:
  - !redirect_valid
  - total < MAX_OUTSTANDING
  - fifo_count + live_cnt < DEPTH
- This credit rule guarantees an rvalid always has FIFO space; no overflow is possible.
- imem_addr = fetch_pc. Held stable while imem_req is high without gnt, unless a redirect occurs.
- Response handling: if discard_cnt > 0, drop the data and decrement discard_cnt. Otherwise it is a live response: pop the PC queue, push the FIFO, decrement live_cnt.
- Output: out_valid = fifo_count != 0. A pop occurs when out_valid && out_ready. Push and pop may happen in the same cycle. FIFO pointers wrap mod DEPTH.
- Redirect, same cycle:
  - FIFO cleared; any pop or push that cycle is ignored.
  - PC queue cleared.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - discard_cnt <= discard_cnt + live_cnt − (rvalid ? 1 : 0); live_cnt <= 0. An rvalid arriving in the redirect cycle is discarded.
  - imem_req forced 0.
- Back-to-back redirects: the last one wins; discard accounting accumulates.
- Reset: all counters 0, FIFO empty, fetch_pc = RESET_PC, independent of any in-flight memory state. The memory side must also be reset.

## Timing
- Reset values: out_valid 0, imem_req 0 while reset_n low. out_pc, out_instr, imem_addr read RESET_PC / 0 (FIFO storage may be uninitialised but is masked by out_valid).
- First request: imem_req = 1 with imem_addr = RESET_PC in the first cycle after reset_n deasserts.
- Latency: gnt in cycle N, rvalid in cycle N+k → out_valid in cycle N+k+1, because the FIFO is registered.
- Throughput: 1 instruction/cycle sustained when k = 1, MAX_OUTSTANDING ≥ 2 and out_ready = 1.
- Redirect at cycle R:
  - imem_req low in R.
  - Request at redirect_pc in R+1 if credit is available.
  - out_valid low in R+1 until new data arrives.
- Stall: with out_ready low, requests stop once fifo_count + live_cnt = DEPTH. Issue resumes the cycle after a pop frees credit.

## Test plan
- Zero-wait memory (gnt = 1, rvalid one cycle later), out_ready = 1 → out_pc = 0x0, 0x4, 0x8, … on consecutive cycles from cycle 2 after reset release; instr words match memory.
- Hold out_ready = 0, DEPTH = 4 → exactly 4 issues, imem_req stays 0, and FIFO holds PCs 0x0–0xC. Raise out_ready → in-order drain, then fetch resumes at 0x10.
- gnt low for 3 cycles → imem_addr stays constant at 0x8 and no duplicate or skipped PCs appear.
- Redirect to 0x103 with 2 requests in flight (3-cycle memory latency) → both stale responses dropped, and the next out_pc is 0x100, then 0x104. No stale instruction ever reaches out_valid.
- Redirect in the same cycle as rvalid and out_ready → that response is dropped, the FIFO is empty next cycle, and imem_req is 0 in the redirect cycle.
- Assert reset_n low mid-stream with a FIFO of 3 entries → out_valid and imem_req drop immediately (asynchronously); after release, fetch restarts at RESET_PC.
